sfilt_mc: RTL and testbench



---
 rtl/sfilt_mc.sv | 167 ++++++++++++++++
 tb/tb_sfilt_mc.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfilt_mc.sv
// Multi-channel serial filter: pipelined q*h multiplier feeding per-channel accumulators
// that support load, accumulate, shift-with-round and output-and-clear.
module sfilt_mc #(
    parameter int DW         = 32,
    parameter int AW         = 64,
    parameter int NCH        = 4,
    parameter int CHW        = 2,
    parameter int MUL_STAGES = 3,
    parameter int SAT        = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           pushin,
    input  logic [1:0]     cmd,
    input  logic [CHW-1:0] ch,
    input  logic [DW-1:0]  q,
    input  logic [DW-1:0]  h,
    output logic           pushout,
    output logic [DW-1:0]  z,
    output logic [CHW-1:0] zch
);
    localparam int SHW = (AW > 1) ? $clog2(AW) : 1;

    typedef struct packed {
        logic                 v;
        logic [1:0]           cmd;
        logic [CHW-1:0]       ch;
        logic [6:0]           sh;
        logic signed [AW-1:0] prod;
    } stage_t;

    logic                 in_v;
    logic [1:0]           in_cmd;
    logic [CHW-1:0]       in_ch;
    logic signed [DW-1:0] in_q;
    logic signed [DW-1:0] in_h;

    logic signed [2*DW-1:0] mul_full;
    stage_t                 ex;

    logic signed [AW-1:0] rd_chain [NCH+1];
    logic [NCH-1:0]       hit;
    logic signed [AW-1:0] cur;
    logic signed [AW-1:0] shifted;
    logic signed [AW-1:0] nxt;
    int unsigned          sh;
    logic [SHW-1:0]       rnd_idx;

    logic                 e_v;
    logic [CHW-1:0]       e_ch;
    logic signed [AW-1:0] e_val;
    logic                 ovf;
    logic [DW-1:0]        zo;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_v   <= 1'b0;
            in_cmd <= '0;
            in_ch  <= '0;
            in_q   <= '0;
            in_h   <= '0;
        end else begin
            in_v   <= pushin;
            in_cmd <= cmd;
            in_ch  <= ch;
            in_q   <= q;
            in_h   <= h;
        end
    end

    assign mul_full = in_q * in_h;

    // Product is formed in the first stage; later stages only delay it with its sideband.
    for (genvar s = 1; s <= MUL_STAGES; s++) begin : g_mul
        stage_t st;
        if (s == 1) begin : g_first
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    st <= '0;
                end else begin
                    st.v    <= in_v;
                    st.cmd  <= in_cmd;
                    st.ch   <= in_ch;
                    st.sh   <= in_h[6:0];
                    st.prod <= AW'(mul_full);
                end
            end
        end else begin : g_next
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    st <= '0;
                end else begin
                    st <= g_mul[s-1].st;
                end
            end
        end
    end

    assign ex = g_mul[MUL_STAGES].st;

    assign rd_chain[0] = '0;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic signed [AW-1:0] acc;

        assign hit[i]          = (ex.ch == CHW'(i));
        assign rd_chain[i + 1] = hit[i] ? acc : rd_chain[i];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                acc <= '0;
            end else if (ex.v && hit[i]) begin
                acc <= nxt;
            end
        end
    end

    always_comb begin
        cur     = rd_chain[NCH];
        sh      = (32'(ex.sh) < AW) ? 32'(ex.sh) : AW;
        shifted = cur >>> sh;
        rnd_idx = (sh != 0) ? SHW'(sh - 1) : '0;
        nxt     = '0;
        case (ex.cmd)
            2'd0: nxt = ex.prod;
            2'd1: nxt = cur + ex.prod;
            2'd2: nxt = (sh == 0) ? cur : shifted + AW'(cur[rnd_idx]);
            default: nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e_v   <= 1'b0;
            e_ch  <= '0;
            e_val <= '0;
        end else begin
            e_v <= ex.v && (ex.cmd == 2'd3) && (|hit);
            if (ex.v && (ex.cmd == 2'd3)) begin
                e_ch  <= ex.ch;
                e_val <= cur;
            end
        end
    end

    always_comb begin
        ovf = (e_val[AW-1:DW-1] != {(AW-DW+1){e_val[AW-1]}});
        zo  = e_val[DW-1:0];
        if ((SAT != 0) && ovf) begin
            zo = e_val[AW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pushout <= 1'b0;
            z       <= '0;
            zch     <= '0;
        end else begin
            pushout <= e_v;
            if (e_v) begin
                z   <= zo;
                zch <= e_ch;
            end
        end
    end
endmodule

// File: tb/tb_sfilt_mc.sv
// Bench for sfilt_mc: four parameterisations share one command stream and are checked
// against an arithmetic per-channel accumulator model with per-instance latency.
module tb_sfilt_mc;
    logic        clk;
    logic        rst_n;
    logic        pushin;
    logic [1:0]  cmd;
    logic [1:0]  ch;
    logic [31:0] q;
    logic [31:0] h;

    logic        po [4];
    logic [31:0] zz [4];
    logic [1:0]  zc [4];

    int lat_k [4] = '{5, 5, 3, 6};
    int nch_k [4] = '{4, 4, 3, 3};
    int sat_k [4] = '{0, 1, 0, 0};

    typedef struct {
        int          at_edge;
        logic [31:0] z;
        logic [1:0]  zch;
    } ev_t;

    ev_t    exp_q [4][$];
    ev_t    obs_q [4][$];
    longint macc  [4][4];

    int cyc = 0;
    int last_edge;
    int checks = 0;
    int errors = 0;

    sfilt_mc #(.DW(32), .AW(64), .NCH(4), .CHW(2), .MUL_STAGES(3), .SAT(0)) d0 (
        .clk(clk), .rst_n(rst_n), .pushin(pushin), .cmd(cmd), .ch(ch), .q(q), .h(h),
        .pushout(po[0]), .z(zz[0]), .zch(zc[0]));
    sfilt_mc #(.DW(32), .AW(64), .NCH(4), .CHW(2), .MUL_STAGES(3), .SAT(1)) d1 (
        .clk(clk), .rst_n(rst_n), .pushin(pushin), .cmd(cmd), .ch(ch), .q(q), .h(h),
        .pushout(po[1]), .z(zz[1]), .zch(zc[1]));
    sfilt_mc #(.DW(32), .AW(64), .NCH(3), .CHW(2), .MUL_STAGES(1), .SAT(0)) d2 (
        .clk(clk), .rst_n(rst_n), .pushin(pushin), .cmd(cmd), .ch(ch), .q(q), .h(h),
        .pushout(po[2]), .z(zz[2]), .zch(zc[2]));
    sfilt_mc #(.DW(32), .AW(64), .NCH(3), .CHW(2), .MUL_STAGES(4), .SAT(0)) d3 (
        .clk(clk), .rst_n(rst_n), .pushin(pushin), .cmd(cmd), .ch(ch), .q(q), .h(h),
        .pushout(po[3]), .z(zz[3]), .zch(zc[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (po[k] === 1'b1) obs_q[k].push_back('{cyc, zz[k], zc[k]});
        end
    end

    function automatic logic [31:0] out_val(input int k, input longint a);
        longint max_v = 64'sd2147483647;
        longint min_v = -64'sd2147483648;
        if (sat_k[k] != 0) begin
            if (a > max_v) return 32'h7FFFFFFF;
            if (a < min_v) return 32'h80000000;
        end
        return a[31:0];
    endfunction

    // Commands take effect in the model at issue time; in-order retirement makes that exact.
    task automatic issue(input int c, input int chn, input int qv, input int hv);
        longint             p;
        int                 s;
        logic signed [65:0] t;
        @(negedge clk);
        pushin    = 1'b1;
        cmd       = 2'(c);
        ch        = 2'(chn);
        q         = qv;
        h         = hv;
        last_edge = cyc + 1;
        p         = longint'(qv) * longint'(hv);
        for (int k = 0; k < 4; k++) begin
            if (chn < nch_k[k]) begin
                case (c)
                    0: macc[k][chn] = p;
                    1: macc[k][chn] = macc[k][chn] + p;
                    2: begin
                        s = hv & 127;
                        if (s > 64) s = 64;
                        if (s != 0) begin
                            t = 66'(macc[k][chn]) + (66'sd1 <<< (s - 1));
                            t = t >>> s;
                            macc[k][chn] = t[63:0];
                        end
                    end
                    default: begin
                        exp_q[k].push_back('{last_edge + lat_k[k], out_val(k, macc[k][chn]), 2'(chn)});
                        macc[k][chn] = 0;
                    end
                endcase
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pushin = 1'b0;
            cmd    = 2'($urandom);
            ch     = 2'($urandom);
            q      = $urandom;
            h      = $urandom;
        end
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        pushin = 1'b0;
        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (po[k] !== 1'b0 || zz[k] !== 32'd0 || zc[k] !== 2'd0) begin
                    errors++;
                    $display("FAIL reset inst%0d: pushout=%b z=%h zch=%0d, want 0 0 0", k, po[k], zz[k], zc[k]);
                end
            end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) for (int c = 0; c < 4; c++) macc[k][c] = 0;
    endtask

    task automatic test_single;
        int e3;
        issue(0, 0, 3, 4);
        issue(1, 0, -2, 5);
        issue(3, 0, 0, 0);
        e3 = last_edge;
        issue(3, 0, 0, 0);
        idle(10);
        #1;
        checks++;
        if (obs_q[0].size() < 2 || obs_q[0][0].z !== 32'd2 || obs_q[0][0].at_edge !== e3 + 5 ||
            obs_q[0][1].z !== 32'd0) begin
            errors++;
            $display("FAIL single direct: %0d pulses, first z=%h at edge %0d, want z=2 at %0d then z=0",
                     obs_q[0].size(), obs_q[0].size() > 0 ? obs_q[0][0].z : 32'hx,
                     obs_q[0].size() > 0 ? obs_q[0][0].at_edge : -1, e3 + 5);
        end
        checks++;
        if (obs_q[2].size() < 1 || obs_q[2][0].at_edge !== e3 + 3) begin
            errors++;
            $display("FAIL latency ms1: edge %0d, want %0d", obs_q[2].size() > 0 ? obs_q[2][0].at_edge : -1, e3 + 3);
        end
        checks++;
        if (obs_q[3].size() < 1 || obs_q[3][0].at_edge !== e3 + 6) begin
            errors++;
            $display("FAIL latency ms4: edge %0d, want %0d", obs_q[3].size() > 0 ? obs_q[3][0].at_edge : -1, e3 + 6);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs_q[k].size() !== exp_q[k].size()) begin
                errors++;
                $display("FAIL single count inst%0d: got %0d pulses, want %0d", k, obs_q[k].size(), exp_q[k].size());
            end else begin
                for (int i = 0; i < exp_q[k].size(); i++) begin
                    checks++;
                    if (obs_q[k][i].at_edge !== exp_q[k][i].at_edge || obs_q[k][i].z !== exp_q[k][i].z ||
                        obs_q[k][i].zch !== exp_q[k][i].zch) begin
                        errors++;
                        $display("FAIL single out inst%0d #%0d: edge %0d z=%h zch=%0d, want edge %0d z=%h zch=%0d",
                                 k, i, obs_q[k][i].at_edge, obs_q[k][i].z, obs_q[k][i].zch,
                                 exp_q[k][i].at_edge, exp_q[k][i].z, exp_q[k][i].zch);
                    end
                end
            end
            obs_q[k].delete();
            exp_q[k].delete();
        end
    endtask

    task automatic test_shift_round;
        logic [31:0] want [5] = '{32'd6, 32'hFFFFFFFA, 32'd0, 32'd23, 32'd0};
        issue(0, 1, 23, 1);   issue(2, 1, 0, 2);            issue(3, 1, 0, 0);
        issue(0, 1, -23, 1);  issue(2, 1, 0, 2);            issue(3, 1, 0, 0);
        issue(0, 1, -1, 1);   issue(2, 1, 0, 64);           issue(3, 1, 0, 0);
        issue(0, 1, 23, 1);   issue(2, 1, 0, 32'hABCDEF80); issue(3, 1, 0, 0);
        issue(0, 1, 12345, -7); issue(2, 1, 0, 100);        issue(3, 1, 0, 0);
        idle(10);
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs_q[0].size() !== 5 || obs_q[0][i].z !== want[i]) begin
                errors++;
                $display("FAIL shift direct #%0d: %0d pulses, z=%h, want 5 pulses z=%h",
                         i, obs_q[0].size(), obs_q[0].size() > i ? obs_q[0][i].z : 32'hx, want[i]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs_q[k].size() !== exp_q[k].size()) begin
                errors++;
                $display("FAIL shift count inst%0d: got %0d pulses, want %0d", k, obs_q[k].size(), exp_q[k].size());
            end else begin
                for (int i = 0; i < exp_q[k].size(); i++) begin
                    checks++;
                    if (obs_q[k][i].at_edge !== exp_q[k][i].at_edge || obs_q[k][i].z !== exp_q[k][i].z ||
                        obs_q[k][i].zch !== exp_q[k][i].zch) begin
                        errors++;
                        $display("FAIL shift out inst%0d #%0d: edge %0d z=%h zch=%0d, want edge %0d z=%h zch=%0d",
                                 k, i, obs_q[k][i].at_edge, obs_q[k][i].z, obs_q[k][i].zch,
                                 exp_q[k][i].at_edge, exp_q[k][i].z, exp_q[k][i].zch);
                    end
                end
            end
            obs_q[k].delete();
            exp_q[k].delete();
        end
    endtask

    task automatic test_interleave;
        issue(0, 0, 2, 3);
        issue(0, 1, 5, 5);
        issue(1, 0, 1, 1);
        issue(1, 1, -1, 4);
        issue(3, 0, 0, 0);
        issue(3, 1, 0, 0);
        idle(10);
        #1;
        checks++;
        if (obs_q[0].size() !== 2 || obs_q[0][0].z !== 32'd7 || obs_q[0][0].zch !== 2'd0 ||
            obs_q[0][1].z !== 32'd21 || obs_q[0][1].zch !== 2'd1 ||
            obs_q[0][1].at_edge !== obs_q[0][0].at_edge + 1) begin
            errors++;
            $display("FAIL interleave direct: %0d pulses, want z=7/zch=0 then z=21/zch=1 on consecutive cycles",
                     obs_q[0].size());
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs_q[k].size() !== exp_q[k].size()) begin
                errors++;
                $display("FAIL interleave count inst%0d: got %0d pulses, want %0d", k, obs_q[k].size(), exp_q[k].size());
            end else begin
                for (int i = 0; i < exp_q[k].size(); i++) begin
                    checks++;
                    if (obs_q[k][i].at_edge !== exp_q[k][i].at_edge || obs_q[k][i].z !== exp_q[k][i].z ||
                        obs_q[k][i].zch !== exp_q[k][i].zch) begin
                        errors++;
                        $display("FAIL interleave out inst%0d #%0d: edge %0d z=%h zch=%0d, want edge %0d z=%h zch=%0d",
                                 k, i, obs_q[k][i].at_edge, obs_q[k][i].z, obs_q[k][i].zch,
                                 exp_q[k][i].at_edge, exp_q[k][i].z, exp_q[k][i].zch);
                    end
                end
            end
            obs_q[k].delete();
            exp_q[k].delete();
        end
    endtask

    task automatic test_saturation;
        issue(0, 0, 32'h7FFFFFFF, 32'h7FFFFFFF);
        issue(3, 0, 0, 0);
        issue(0, 0, 32'h80000000, 32'h7FFFFFFF);
        issue(3, 0, 0, 0);
        idle(10);
        #1;
        checks++;
        if (obs_q[1].size() !== 2 || obs_q[1][0].z !== 32'h7FFFFFFF || obs_q[1][1].z !== 32'h80000000) begin
            errors++;
            $display("FAIL sat direct: %0d pulses, want 7fffffff then 80000000", obs_q[1].size());
        end
        checks++;
        if (obs_q[0].size() !== 2 || obs_q[0][0].z !== 32'h00000001) begin
            errors++;
            $display("FAIL trunc direct: %0d pulses, want first z=00000001", obs_q[0].size());
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs_q[k].size() !== exp_q[k].size()) begin
                errors++;
                $display("FAIL sat count inst%0d: got %0d pulses, want %0d", k, obs_q[k].size(), exp_q[k].size());
            end else begin
                for (int i = 0; i < exp_q[k].size(); i++) begin
                    checks++;
                    if (obs_q[k][i].at_edge !== exp_q[k][i].at_edge || obs_q[k][i].z !== exp_q[k][i].z ||
                        obs_q[k][i].zch !== exp_q[k][i].zch) begin
                        errors++;
                        $display("FAIL sat out inst%0d #%0d: edge %0d z=%h zch=%0d, want edge %0d z=%h zch=%0d",
                                 k, i, obs_q[k][i].at_edge, obs_q[k][i].z, obs_q[k][i].zch,
                                 exp_q[k][i].at_edge, exp_q[k][i].z, exp_q[k][i].zch);
                    end
                end
            end
            obs_q[k].delete();
            exp_q[k].delete();
        end
    endtask

    task automatic test_reset_midflight;
        issue(0, 2, 9, 9);
        issue(3, 2, 0, 0);
        idle(1);
        @(negedge clk);
        pushin = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_q[k].delete();
            for (int c = 0; c < 4; c++) macc[k][c] = 0;
            checks++;
            if (po[k] !== 1'b0 || zz[k] !== 32'd0 || zc[k] !== 2'd0) begin
                errors++;
                $display("FAIL midreset outputs inst%0d: pushout=%b z=%h zch=%0d, want 0 0 0", k, po[k], zz[k], zc[k]);
            end
        end
        idle(10);
        issue(3, 2, 0, 0);
        idle(10);
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs_q[k].size() !== exp_q[k].size()) begin
                errors++;
                $display("FAIL midreset count inst%0d: got %0d pulses, want %0d", k, obs_q[k].size(), exp_q[k].size());
            end else begin
                for (int i = 0; i < exp_q[k].size(); i++) begin
                    checks++;
                    if (obs_q[k][i].at_edge !== exp_q[k][i].at_edge || obs_q[k][i].z !== exp_q[k][i].z ||
                        obs_q[k][i].zch !== exp_q[k][i].zch) begin
                        errors++;
                        $display("FAIL midreset out inst%0d #%0d: edge %0d z=%h zch=%0d, want edge %0d z=%h zch=%0d",
                                 k, i, obs_q[k][i].at_edge, obs_q[k][i].z, obs_q[k][i].zch,
                                 exp_q[k][i].at_edge, exp_q[k][i].z, exp_q[k][i].zch);
                    end
                end
            end
            obs_q[k].delete();
            exp_q[k].delete();
        end
    endtask

    // Random mix including ch=3, which the NCH=3 instances must drop.
    task automatic test_random;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else issue(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom), int'($urandom));
        end
        for (int c = 0; c < 4; c++) issue(3, c, 0, 0);
        idle(10);
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs_q[k].size() !== exp_q[k].size()) begin
                errors++;
                $display("FAIL random count inst%0d: got %0d pulses, want %0d", k, obs_q[k].size(), exp_q[k].size());
            end else begin
                for (int i = 0; i < exp_q[k].size(); i++) begin
                    checks++;
                    if (obs_q[k][i].at_edge !== exp_q[k][i].at_edge || obs_q[k][i].z !== exp_q[k][i].z ||
                        obs_q[k][i].zch !== exp_q[k][i].zch) begin
                        errors++;
                        $display("FAIL random out inst%0d #%0d: edge %0d z=%h zch=%0d, want edge %0d z=%h zch=%0d",
                                 k, i, obs_q[k][i].at_edge, obs_q[k][i].z, obs_q[k][i].zch,
                                 exp_q[k][i].at_edge, exp_q[k][i].z, exp_q[k][i].zch);
                    end
                end
            end
            obs_q[k].delete();
            exp_q[k].delete();
        end
    endtask

    initial begin
        pushin = 1'b0;
        cmd    = '0;
        ch     = '0;
        q      = '0;
        h      = '0;
        test_reset();
        test_single();
        test_shift_round();
        test_interleave();
        test_saturation();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
